// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
// Module : id_stage
// Brief  : IF/ID register, 32x32 register file, hazard detection, branch
//          resolution and the registered ID/EX bundle.
// Rev    : 1.0
// ============================================================================
module id_stage #(
    parameter logic [31:0] NOP = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC,
    input  logic [31:0] instruction,
    input  logic        wb_en,
    input  logic [4:0]  wb_dest,
    input  logic [31:0] wb_data,
    input  logic [4:0]  exmem_dest,
    input  logic        exmem_reg_write,
    output logic        BranchTaken,
    output logic [31:0] BranchOffset,
    output logic        PCWrite,
    output logic [31:0] id_ex_pc,
    output logic [31:0] id_ex_reg1,
    output logic [31:0] id_ex_reg2,
    output logic [31:0] id_ex_imm,
    output logic [4:0]  id_ex_dest,
    output logic [5:0]  id_ex_opcode,
    output logic [5:0]  id_ex_funct,
    output logic        id_ex_reg_write,
    output logic        id_ex_mem_read,
    output logic        id_ex_mem_write
);

    localparam logic [5:0] c_op_rtype = 6'h00;
    localparam logic [5:0] c_op_lw    = 6'h23;
    localparam logic [5:0] c_op_sw    = 6'h2B;
    localparam logic [5:0] c_op_addi  = 6'h08;
    localparam logic [5:0] c_op_beq   = 6'h04;
    localparam logic [5:0] c_op_bne   = 6'h05;

    logic [31:0] ifid_pc_q, ifid_pc_d, ifid_instr_q, ifid_instr_d;
    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];

    logic [31:0] id_ex_pc_q, id_ex_pc_d, id_ex_reg1_q, id_ex_reg1_d;
    logic [31:0] id_ex_reg2_q, id_ex_reg2_d, id_ex_imm_q, id_ex_imm_d;
    logic [4:0]  id_ex_dest_q, id_ex_dest_d;
    logic [5:0]  id_ex_opcode_q, id_ex_opcode_d, id_ex_funct_q, id_ex_funct_d;
    logic        id_ex_reg_write_q, id_ex_reg_write_d;
    logic        id_ex_mem_read_q, id_ex_mem_read_d;
    logic        id_ex_mem_write_q, id_ex_mem_write_d;

    logic [5:0]  w_op;
    logic [4:0]  w_rs, w_rt, w_rd, w_dest;
    logic        w_rd_rs, w_rd_rt, w_wr, w_mr, w_mw, w_beq, w_bne;
    logic [31:0] w_rs_val, w_rt_val, w_imm;
    logic        w_idex_hit, w_exmem_hit, w_load_use, w_br_haz;

    assign w_op  = ifid_instr_q[31:26];
    assign w_rs  = ifid_instr_q[25:21];
    assign w_rt  = ifid_instr_q[20:16];
    assign w_rd  = ifid_instr_q[15:11];
    assign w_imm = {{16{ifid_instr_q[15]}}, ifid_instr_q[15:0]};

    always_comb begin
        w_rd_rs = 1'b0;
        w_rd_rt = 1'b0;
        w_wr    = 1'b0;
        w_mr    = 1'b0;
        w_mw    = 1'b0;
        w_beq   = 1'b0;
        w_bne   = 1'b0;
        w_dest  = 5'd0;
        case (w_op)
            c_op_rtype: begin w_rd_rs = 1'b1; w_rd_rt = 1'b1; w_dest = w_rd; w_wr = 1'b1; end
            c_op_lw:    begin w_rd_rs = 1'b1; w_dest = w_rt; w_wr = 1'b1; w_mr = 1'b1; end
            c_op_sw:    begin w_rd_rs = 1'b1; w_rd_rt = 1'b1; w_mw = 1'b1; end
            c_op_addi:  begin w_rd_rs = 1'b1; w_dest = w_rt; w_wr = 1'b1; end
            c_op_beq:   begin w_rd_rs = 1'b1; w_rd_rt = 1'b1; w_beq = 1'b1; end
            c_op_bne:   begin w_rd_rs = 1'b1; w_rd_rt = 1'b1; w_bne = 1'b1; end
            default:    ;
        endcase
        if (w_dest == 5'd0) w_wr = 1'b0;
    end

    // Read ports: x0 wins over the write-first bypass, which wins over the array.
    always_comb begin
        w_rs_val = regs_q[w_rs];
        if (wb_en && (wb_dest == w_rs)) w_rs_val = wb_data;
        if (w_rs == 5'd0) w_rs_val = 32'd0;
        w_rt_val = regs_q[w_rt];
        if (wb_en && (wb_dest == w_rt)) w_rt_val = wb_data;
        if (w_rt == 5'd0) w_rt_val = 32'd0;
    end

    assign w_idex_hit  = (w_rd_rs && (id_ex_dest_q == w_rs)) || (w_rd_rt && (id_ex_dest_q == w_rt));
    assign w_exmem_hit = exmem_reg_write && (exmem_dest != 5'd0) &&
                         ((w_rd_rs && (exmem_dest == w_rs)) || (w_rd_rt && (exmem_dest == w_rt)));
    assign w_load_use  = id_ex_mem_read_q && (id_ex_dest_q != 5'd0) && w_idex_hit;
    assign w_br_haz    = (w_beq || w_bne) && ((id_ex_reg_write_q && w_idex_hit) || w_exmem_hit);

    assign PCWrite      = w_load_use || w_br_haz;
    assign BranchTaken  = ((w_beq && (w_rs_val == w_rt_val)) || (w_bne && (w_rs_val != w_rt_val))) && !PCWrite;
    assign BranchOffset = w_imm;

    always_comb begin
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        if (!PCWrite) begin
            if (BranchTaken) begin
                ifid_instr_d = NOP;
            end else begin
                ifid_pc_d    = PC;
                ifid_instr_d = instruction;
            end
        end
    end

    always_comb begin
        regs_d = regs_q;
        if (wb_en && (wb_dest != 5'd0)) regs_d[wb_dest] = wb_data;
    end

    // A stall inserts an all-zero bubble; fields of unread operands are zeroed.
    always_comb begin
        id_ex_pc_d        = 32'd0;
        id_ex_reg1_d      = 32'd0;
        id_ex_reg2_d      = 32'd0;
        id_ex_imm_d       = 32'd0;
        id_ex_dest_d      = 5'd0;
        id_ex_opcode_d    = 6'd0;
        id_ex_funct_d     = 6'd0;
        id_ex_reg_write_d = 1'b0;
        id_ex_mem_read_d  = 1'b0;
        id_ex_mem_write_d = 1'b0;
        if (!PCWrite) begin
            id_ex_pc_d        = ifid_pc_q;
            id_ex_reg1_d      = w_rd_rs ? w_rs_val : 32'd0;
            id_ex_reg2_d      = w_rd_rt ? w_rt_val : 32'd0;
            id_ex_imm_d       = w_imm;
            id_ex_dest_d      = w_dest;
            id_ex_opcode_d    = w_op;
            id_ex_funct_d     = ifid_instr_q[5:0];
            id_ex_reg_write_d = w_wr;
            id_ex_mem_read_d  = w_mr;
            id_ex_mem_write_d = w_mw;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ifid_pc_q         <= 32'd0;
            ifid_instr_q      <= NOP;
            id_ex_pc_q        <= 32'd0;
            id_ex_reg1_q      <= 32'd0;
            id_ex_reg2_q      <= 32'd0;
            id_ex_imm_q       <= 32'd0;
            id_ex_dest_q      <= 5'd0;
            id_ex_opcode_q    <= 6'd0;
            id_ex_funct_q     <= 6'd0;
            id_ex_reg_write_q <= 1'b0;
            id_ex_mem_read_q  <= 1'b0;
            id_ex_mem_write_q <= 1'b0;
        end else begin
            ifid_pc_q         <= ifid_pc_d;
            ifid_instr_q      <= ifid_instr_d;
            id_ex_pc_q        <= id_ex_pc_d;
            id_ex_reg1_q      <= id_ex_reg1_d;
            id_ex_reg2_q      <= id_ex_reg2_d;
            id_ex_imm_q       <= id_ex_imm_d;
            id_ex_dest_q      <= id_ex_dest_d;
            id_ex_opcode_q    <= id_ex_opcode_d;
            id_ex_funct_q     <= id_ex_funct_d;
            id_ex_reg_write_q <= id_ex_reg_write_d;
            id_ex_mem_read_q  <= id_ex_mem_read_d;
            id_ex_mem_write_q <= id_ex_mem_write_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
        end else begin
            regs_q <= regs_d;
        end
    end

    assign id_ex_pc        = id_ex_pc_q;
    assign id_ex_reg1      = id_ex_reg1_q;
    assign id_ex_reg2      = id_ex_reg2_q;
    assign id_ex_imm       = id_ex_imm_q;
    assign id_ex_dest      = id_ex_dest_q;
    assign id_ex_opcode    = id_ex_opcode_q;
    assign id_ex_funct     = id_ex_funct_q;
    assign id_ex_reg_write = id_ex_reg_write_q;
    assign id_ex_mem_read  = id_ex_mem_read_q;
    assign id_ex_mem_write = id_ex_mem_write_q;

endmodule
`default_nettype wire

// File: doc/id_stage.md
# id_stage

Instruction-decode stage directly downstream of the fetch stage. Holds the IF/ID pipeline register, the 32×32 register file, load-use/branch hazard detection and branch resolution. Produces the fetch stage's `BranchTaken`, `BranchOffset` and `PCWrite` (freeze) inputs, and a registered ID/EX bundle for the execute stage.

## Interface
Parameters:
- `NOP`, 32'h0000_0000: instruction word loaded into IF/ID on flush or reset.

Ports:
- `clk`  input  1  rising-edge clock
- `rst`  input  1  asynchronous, active-low reset
- `PC`  input  32  fetch-stage PC; the address following the fetched instruction
- `instruction`  input  32  fetched instruction word
- `wb_en`  input  1  write-back enable
- `wb_dest`  input  5  write-back register index
- `wb_data`  input  32  write-back data
- `exmem_dest`  input  5  destination of the instruction in MEM
- `exmem_reg_write`  input  1  MEM-stage instruction writes a register
- `BranchTaken`  output  1  combinational; redirect fetch
- `BranchOffset`  output  32  combinational; sign-extended imm16 in words; fetch shifts it left by 2
- `PCWrite`  output  1  combinational freeze; 1 holds the PC and IF/ID
- `id_ex_pc`, `id_ex_reg1`, `id_ex_reg2`, `id_ex_imm`  output  32 each  registered PC, rs value, rt value, sign-extended imm16
- `id_ex_dest`  output  5  registered destination index
- `id_ex_opcode`, `id_ex_funct`  output  6 each  registered instruction fields
- `id_ex_reg_write`, `id_ex_mem_read`, `id_ex_mem_write`  output  1 each  registered controls

## Operation
- **IF/ID register:** `ifid_pc`, `ifid_instr`.
  - Loads `PC`/`instruction` each cycle.
  - Holds when `PCWrite`=1.
  - Loads `NOP` (PC field unchanged) when `BranchTaken`=1.
- **Decode subset.** Any other opcode is a NOP: no read, no write, no memory.
  - op 0x00 (R): reads rs and rt; dest = rd; reg_write = 1.
  - 0x23 lw: reads rs; dest = rt; reg_write = 1; mem_read = 1.
  - 0x2B sw: reads rs and rt; mem_write = 1.
  - 0x08 addi: reads rs; dest = rt; reg_write = 1.
  - 0x04 beq, 0x05 bne: read rs and rt; no write.
  - An instruction with dest = 0 has reg_write forced to 0.
- **Register file:**
  - 32×32, two combinational read ports, one write on the rising edge when `wb_en` and `wb_dest`≠0.
  - Register 0 always reads 0.
  - Write-first bypass: a read of `wb_dest` while `wb_en` is high returns `wb_data`.
- **Hazard detection (`PCWrite`=1 when any of these hold):**
  - Load-use: `id_ex_mem_read`=1, `id_ex_dest`≠0, and `id_ex_dest` equals a register the IF/ID instruction reads.
  - Branch: the IF/ID instruction is beq/bne and either:
    - `id_ex_reg_write`=1 with `id_ex_dest` matching rs or rt, or
    - `exmem_reg_write`=1 with `exmem_dest` (≠0) matching rs or rt.
- **Branch resolution:**
  - `BranchTaken` = (beq and rs_val==rt_val, or bne and rs_val≠rt_val) and not `PCWrite`.
  - `BranchOffset` = sign-extended `ifid_instr[15:0]`; it is driven continuously, whether or not the branch is taken.
  - Target = branch address + 4 + offset×4. There is no delay slot; the wrong-path instruction is flushed.
- **ID/EX register:**
  - Loads the decoded bundle each cycle.
  - When `PCWrite`=1, loads a bubble: all controls 0, `id_ex_dest`=0. Data fields don't care; drive them to 0.
  - Branches pass through as no-write, no-memory entries.

## Timing
- **Reset (`rst`=0), applied asynchronously:**
  - IF/ID holds `NOP`, PC 0.
  - All ID/EX outputs are 0.
  - All 32 registers are 0.
  - So `BranchTaken`=0 and `PCWrite`=0.
- **Reset mid-operation:** everything clears immediately and the pending write-back is discarded. Release is synchronous to the next clock edge.
- **Latency:** fetch → IF/ID takes 1 edge; IF/ID → ID/EX takes 1 edge.
- **Branch penalty:** exactly 1 bubble when taken, 0 when not taken.
- **Load-use stall:** exactly 1 cycle.
  - The cycle after the stall, the lw is in MEM. `exmem_*` does not trigger a stall for non-branches; forwarding downstream handles it.
- **Branch-after-ALU:** stalls 2 cycles.
- **Branch-after-load:** stalls 2 cycles.
- **Write-back to a register read in the same cycle:** resolved by the bypass, no stall.
- **`PCWrite` and a flush together:** `PCWrite` wins; a branch is never taken while stalled.

## Test plan
- **Reset:** assert `rst`=0 mid-stream → all outputs 0 at once; `id_ex_reg_write`=0; reading x5 afterwards returns 0.
- **Write-back bypass:** `wb_en`=1, `wb_dest`=3, `wb_data`=0xDEADBEEF; same-cycle decode of `add x4,x3,x0` → `id_ex_reg1`=0xDEADBEEF. Write with `wb_dest`=0 → x0 still reads 0.
- **Load-use:** `lw x2,0(x1)` then `add x3,x2,x2` → `PCWrite`=1 for 1 cycle, one ID/EX bubble; add issues on the following cycle with `id_ex_dest`=3.
- **beq taken:** x1=x2=7, `beq x1,x2,+3` → `BranchTaken`=1, `BranchOffset`=3; the next IF/ID holds `NOP`. Offset 0xFFFE → `BranchOffset`=32'hFFFF_FFFE.
- **bne not taken:** x1=x2 → `BranchTaken`=0, no bubble.
- **Branch-after-ALU:** `addi x1,x0,5` then `beq x1,x0,+2` → `PCWrite`=1 for 2 cycles, then `BranchTaken`=0.
